// File: rtl/sram_arbiter.sv
// Purpose: two-port arbiter and SPI sequencer for a shared 23LC1024-style serial SRAM.
// Latency: grant to resp_valid is 2N+2 cycles (N = 32 + 8*bytes): 82 / 98 / 130.
// Backpressure: req_ready pulses only in IDLE; requests wait through SHIFT/DONE/GAP.
//
// Ports:
//   clk, reset (sync, active low)
//   req_valid/req_ready/req_we[1:0], req_addr0/1, req_size0/1, req_wdata0/1 : request side
//   resp_valid[1:0], resp_rdata, busy                                      : response side
//   sram_ce, sclk, si (out), so (in)                                       : SPI mode 0 bus
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration on contention;
// without it port 0 has fixed priority over port 1.
module sram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [23:0] req_addr0,
  input  logic [23:0] req_addr1,
  input  logic [1:0]  req_size0,
  input  logic [1:0]  req_size1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic        sram_ce,
  output logic        sclk,
  output logic        si,
  input  logic        so
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_GAP} state_t;

  state_t      state_q;
  logic        owner_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [63:0] shreg_q;
  logic [31:0] rx_q;
  logic [5:0]  bit_cnt_q;
  logic        ce_q;
  logic        sclk_q;
  logic        si_q;
  logic        busy_q;
  logic [1:0]  resp_valid_q;
  logic [31:0] rdata_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] grant;

`ifdef SRAM_ARB_RR_EN
  // Port that wins the next contended cycle (0 or 1).
  logic rr_q;

  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end else begin
      grant = req_valid;
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    if (req_valid[0]) begin
      grant = 2'b01;
    end else if (req_valid[1]) begin
      grant = 2'b10;
    end
  end
`endif

  // Gated with reset so no accept is shown while reset is being held.
  assign req_ready = (state_q == S_IDLE && reset) ? grant : 2'b00;

  // ---------------------------------------------------------------------------
  // Selected request and SPI frame
  // ---------------------------------------------------------------------------
  logic        sel;
  logic        sel_we;
  logic [23:0] sel_addr;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;
  logic [31:0] data_bytes;
  logic [63:0] frame;
  logic [5:0]  nbits_m1;

  assign sel       = grant[1];
  assign sel_we    = sel ? req_we[1]  : req_we[0];
  assign sel_addr  = sel ? req_addr1  : req_addr0;
  assign sel_size  = sel ? req_size1  : req_size0;
  assign sel_wdata = sel ? req_wdata1 : req_wdata0;

  // Byte 0 goes out first; reads send zeros so si stays low in the data phase.
  assign data_bytes = sel_we ? {sel_wdata[7:0], sel_wdata[15:8], sel_wdata[23:16], sel_wdata[31:24]}
                             : 32'h0;
  assign frame = {(sel_we ? 8'h02 : 8'h03), sel_addr, data_bytes};

  always_comb begin
    case (sel_size)
      2'd0:    nbits_m1 = 6'd39;
      2'd1:    nbits_m1 = 6'd47;
      default: nbits_m1 = 6'd63;
    endcase
  end

  // rx_q holds the last 32 bits shifted in, first received byte most significant
  // within the data window; reorder so the byte at addr lands in [7:0].
  logic [31:0] rd_data;

  always_comb begin
    case (size_q)
      2'd0:    rd_data = {24'h0, rx_q[7:0]};
      2'd1:    rd_data = {16'h0, rx_q[7:0], rx_q[15:8]};
      default: rd_data = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      shreg_q      <= 64'h0;
      rx_q         <= 32'h0;
      bit_cnt_q    <= 6'd0;
      ce_q         <= 1'b1;
      sclk_q       <= 1'b0;
      si_q         <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 2'b00;
      rdata_q      <= 32'h0;
`ifdef SRAM_ARB_RR_EN
      rr_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant != 2'b00) begin
            owner_q   <= sel;
            we_q      <= sel_we;
            size_q    <= sel_size;
            // First bit is driven straight away; the rest waits in shreg_q.
            si_q      <= frame[63];
            shreg_q   <= {frame[62:0], 1'b0};
            bit_cnt_q <= nbits_m1;
            ce_q      <= 1'b0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_SHIFT;
`ifdef SRAM_ARB_RR_EN
            rr_q      <= grant[0];
`endif
          end
        end

        S_SHIFT: begin
          if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else begin
            // Falling SCLK edge: capture so and move to the next bit.
            sclk_q <= 1'b0;
            rx_q   <= {rx_q[30:0], so};
            if (bit_cnt_q == 6'd0) begin
              ce_q    <= 1'b1;
              si_q    <= 1'b0;
              state_q <= S_DONE;
            end else begin
              si_q      <= shreg_q[63];
              shreg_q   <= {shreg_q[62:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - 6'd1;
            end
          end
        end

        S_DONE: begin
          resp_valid_q <= owner_q ? 2'b10 : 2'b01;
          rdata_q      <= we_q ? 32'h0 : rd_data;
          state_q      <= S_GAP;
        end

        S_GAP: begin
          // First GAP cycle carries the response pulse; the second is the
          // deselect gap before the next grant.
          resp_valid_q <= 2'b00;
          if (resp_valid_q == 2'b00) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign busy       = busy_q;
  assign sram_ce    = ce_q;
  assign sclk       = sclk_q;
  assign si         = si_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [23:0] req_addr0, req_addr1;
  logic [1:0]  req_size0, req_size1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        sram_ce;
  logic        sclk;
  logic        si;
  logic        so = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  sram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_size0  (req_size0),
    .req_size1  (req_size1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy),
    .sram_ce    (sram_ce),
    .sclk       (sclk),
    .si         (si),
    .so         (so)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Serial SRAM model (mode 0, sequential, 24-bit wrap)
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [int];
  int          bitn = 0;
  int          last_bits = 0;
  int          txn_cnt = 0;
  logic [31:0] sh = 32'h0;
  logic [7:0]  m_cmd = 8'h00;
  logic [23:0] m_addr = 24'h0;
  logic [23:0] wa, ra;
  logic [7:0]  rb;
  int          idx;

  function automatic logic [7:0] rd_mem(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 8'h00;
  endfunction

  always @(negedge sram_ce) begin
    bitn = 0;
    txn_cnt++;
  end

  always @(posedge sram_ce) last_bits = bitn;

  always @(posedge sclk) begin
    if (sram_ce === 1'b0) begin
      sh = {sh[30:0], si};
      bitn++;
      if (bitn == 8)  m_cmd  = sh[7:0];
      if (bitn == 32) m_addr = sh[23:0];
      if (m_cmd == 8'h02 && bitn > 32 && (bitn - 32) % 8 == 0) begin
        wa = m_addr + 24'((bitn - 40) / 8);
        mem[int'(wa)] = sh[7:0];
      end
    end
  end

  always @(negedge sclk) begin
    if (sram_ce === 1'b0 && m_cmd == 8'h03 && bitn >= 32) begin
      idx = bitn - 32;
      ra  = m_addr + 24'(idx / 8);
      rb  = rd_mem(ra);
      #1 so = rb[7 - (idx % 8)];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic set_req(input bit p, input bit we, input logic [23:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    req_we[p] = we;
    if (p) begin
      req_addr1 = a; req_size1 = s; req_wdata1 = d;
    end else begin
      req_addr0 = a; req_size0 = s; req_wdata0 = d;
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [23:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [7:0]  exp_cmd;
    int          exp_bits;
  } vec_t;

  // Runs one isolated transaction; entered and left just after a rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    int  t0;
    bit  got;
    set_req(v.port, v.we, v.addr, v.size, v.wdata);
    req_valid[v.port] = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[v.port]) got = 1;
    end
    if (!got) begin
      timeout({tag, "_grant"});
      req_valid = 2'b00;
      return;
    end
    t0 = cyc;
    @(posedge clk);
    #1 req_valid[v.port] = 1'b0;
    @(negedge clk);
    chk({tag, "_ce_low_T1"}, 64'(sram_ce), 64'(0));
    chk({tag, "_busy_T1"}, 64'(busy), 64'(1));
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) got = 1;
    end
    if (!got) begin
      timeout({tag, "_resp"});
      return;
    end
    chk({tag, "_latency"}, 64'(cyc - t0), 64'(v.exp_lat));
    chk({tag, "_resp_owner"}, 64'(resp_valid), v.port ? 64'(2) : 64'(1));
    chk({tag, "_rdata"}, 64'(resp_rdata), 64'(v.exp_rdata));
    chk({tag, "_ce_done"}, 64'(sram_ce), 64'(1));
    chk({tag, "_cmd"}, 64'(m_cmd), 64'(v.exp_cmd));
    chk({tag, "_addr"}, 64'(m_addr), 64'(v.addr));
    chk({tag, "_bits"}, 64'(last_bits), 64'(v.exp_bits));
    @(negedge clk);
    chk({tag, "_busy_gap"}, 64'(busy), 64'(1));
    chk({tag, "_resp_pulse"}, 64'(resp_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];
  bit   exp_own[4];
  int   gcyc[4];
  bit   gown[4];
  int   t0, base, cnt;
  bit   got;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //               port we addr        size wdata         exp_rdata     lat  cmd    bits
    vecs[0] = '{1'b0, 1'b1, 24'h000010, 2'd2, 32'hDEADBEEF, 32'h00000000, 130, 8'h02, 64};
    vecs[1] = '{1'b0, 1'b0, 24'h000010, 2'd2, 32'h00000000, 32'hDEADBEEF, 130, 8'h03, 64};
    vecs[2] = '{1'b1, 1'b0, 24'hFFFFFF, 2'd0, 32'h00000000, 32'h0000005A,  82, 8'h03, 40};
    vecs[3] = '{1'b1, 1'b0, 24'hFFFFFF, 2'd1, 32'h00000000, 32'h0000A55A,  98, 8'h03, 48};
    vecs[4] = '{1'b1, 1'b1, 24'h000100, 2'd1, 32'h1234CAFE, 32'h00000000,  98, 8'h02, 48};
    vecs[5] = '{1'b0, 1'b0, 24'h000100, 2'd3, 32'h00000000, 32'h0000CAFE, 130, 8'h03, 64};
    vecs[6] = '{1'b0, 1'b1, 24'h000200, 2'd0, 32'hAABBCC77, 32'h00000000,  82, 8'h02, 40};
    vecs[7] = '{1'b1, 1'b0, 24'h000200, 2'd0, 32'h00000000, 32'h00000077,  82, 8'h03, 40};
`ifdef SRAM_ARB_RR_EN
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    mem[int'(24'hFFFFFF)] = 8'h5A;
    mem[0] = 8'hA5;

    // Reset held with both ports requesting.
    reset = 1'b0;
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr0 = 24'h0; req_addr1 = 24'h0;
    req_size0 = 2'd0;  req_size1 = 2'd0;
    req_wdata0 = 32'h0; req_wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sram_ce", 64'(sram_ce), 64'(1));
    chk("rst_sclk", 64'(sclk), 64'(0));
    chk("rst_si", 64'(si), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1; req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    chk("mem_0x10", 64'(rd_mem(24'h10)), 64'(8'hEF));
    chk("mem_0x11", 64'(rd_mem(24'h11)), 64'(8'hBE));
    chk("mem_0x12", 64'(rd_mem(24'h12)), 64'(8'hAD));
    chk("mem_0x13", 64'(rd_mem(24'h13)), 64'(8'hDE));

    // Contention: both ports hold valid for four grants.
    set_req(1'b0, 1'b0, 24'h000010, 2'd2, 32'h0);
    set_req(1'b1, 1'b0, 24'hFFFFFF, 2'd0, 32'h0);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (resp_valid != 2'b00)
          chk("cont_rdata", 64'(resp_rdata), resp_valid[1] ? 64'h5A : 64'hDEADBEEF);
        if (req_ready != 2'b00) got = 1;
      end
      if (!got) begin
        timeout("cont_grant");
        break;
      end
      gcyc[g] = cyc;
      gown[g] = req_ready[1];
      chk($sformatf("cont_owner%0d", g), 64'(gown[g]), 64'(exp_own[g]));
      chk("cont_onehot", 64'($countones(req_ready)), 64'(1));
      if (g > 0)
        chk("cont_spacing", 64'(gcyc[g] - gcyc[g-1]), gown[g-1] ? 64'(84) : 64'(132));
      if (g < 3) @(posedge clk);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) timeout("cont_drain");
    @(posedge clk);
    #1;

    // Port 1 withdraws in the cycle port 0 is granted.
    set_req(1'b0, 1'b0, 24'h000010, 2'd0, 32'h0);
    set_req(1'b1, 1'b1, 24'h000300, 2'd0, 32'h000000C3);
    req_valid = 2'b11;
    @(negedge clk);
    chk("wd_ready", 64'(req_ready), 64'(1));
    t0 = cyc;
    base = txn_cnt;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    cnt = 0;
    got = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (req_ready[1]) cnt++;
      if (resp_valid != 2'b00) begin
        got = 1;
        chk("wd_latency", 64'(cyc - t0), 64'(82));
        chk("wd_rdata", 64'(resp_rdata), 64'h000000EF);
      end
    end
    if (!got) timeout("wd_resp");
    chk("wd_p1_ready", 64'(cnt), 64'(0));
    chk("wd_txns", 64'(txn_cnt - base), 64'(1));
    chk("wd_no_write", 64'(mem.exists(int'(24'h300))), 64'(0));
    @(posedge clk);
    #1;

    // Reset 40 cycles into a word read.
    set_req(1'b0, 1'b0, 24'h000010, 2'd2, 32'h0);
    req_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    if (!got) timeout("mrst_grant");
    t0 = cyc;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (39) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_ce_before", 64'(sram_ce), 64'(0));
    @(negedge clk);
    chk("mrst_cycle", 64'(cyc - t0), 64'(41));
    chk("mrst_ce_high", 64'(sram_ce), 64'(1));
    chk("mrst_sclk", 64'(sclk), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_rdata", 64'(resp_rdata), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) cnt++;
    end
    chk("mrst_no_resp", 64'(cnt), 64'(0));
    @(posedge clk);
    #1;
    run_vec(vecs[7], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and SPI sequencer for the shared external serial SRAM (23LC1024-style, SPI mode 0, sequential mode). It sits between the CPU memory interface (port 0) and the radio DMA engine (port 1), grants one request at a time and drives `sclk`/`si`/`sram_ce`/`so`. Each granted request runs as one complete SRAM transaction: READ 0x03 or WRITE 0x02, then a 24-bit address, then 1, 2 or 4 data bytes. The requester gets back a single-cycle response pulse.

## Interface

- No parameters; SCLK is fixed at clk/2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid[1:0]`  in  2  request per port; held with its fields until accepted.
- `req_ready[1:0]`  out  2  one-cycle grant (accept) pulse per port.
- `req_we[1:0]`  in  2  per port: 1 = write, 0 = read.
- `req_addr0`, `req_addr1`  in  24  byte address.
- `req_size0`, `req_size1`  in  2  transfer size: 0 = byte, 1 = half, 2 = word, 3 = word.
- `req_wdata0`, `req_wdata1`  in  32  write data, little-endian.
- `resp_valid[1:0]`  out  2  one-cycle completion pulse for the owning port.
- `resp_rdata`  out  32  read data, shared by both ports; valid while `resp_valid` is high; unused bytes are zero.
- `busy`  out  1  high from grant until the cycle after `resp_valid`.
- `sram_ce`  out  1  SRAM chip enable, active low.
- `sclk`  out  1  SPI clock; idles low.
- `si`  out  1  master-out data into the SRAM.
- `so`  in  1  SRAM data out to the master.

## Operation

- **FSM states:** IDLE → SHIFT → DONE → GAP → IDLE.
- **IDLE:**
  - `req_ready` is combinational: the arbitration result of `req_valid`.
  - On a grant, the selected port's we/addr/size/wdata are latched and the owner is recorded.
  - The next state is SHIFT.
- **SHIFT:**
  - Shifts out N = 32 + 8·B bits, MSB first, where B = 1, 2 or 4 bytes.
  - Command byte first, then the 24-bit address, then the data bits.
  - Write data goes out byte `wdata[7:0]` first; within each byte, MSB first.
  - Read data: the byte at `addr` lands in `rdata[7:0]`, `addr+1` in `[15:8]`, and so on.
  - During the read data phase `si` is held at 0.
- **Per bit (2 clk cycles):**
  - Cycle A: `sclk` = 0 and `si` holds the current bit.
  - Cycle B: `sclk` = 1.
  - `so` is sampled on the clk edge that returns `sclk` from 1 to 0.
- **DONE:**
  - `sram_ce` goes high and `sclk` goes low.
  - `resp_valid[owner]` is high for exactly one cycle, with `resp_rdata` valid (zero for writes).
- **GAP:** one cycle with `sram_ce` high (minimum deselect time), then IDLE.
- **Address wrap:** the 24-bit address wraps from 0xFFFFFF to 0x000000 inside a multi-byte access. This wrap is done by the SRAM itself; the block does no splitting.
- **Valid withdrawn:** dropping `req_valid` before `req_ready` is legal and starts no transaction.
- **Requests during SHIFT/DONE/GAP:** `req_ready` stays 0; the requests wait.
- **Reset mid-transaction:** the transaction is aborted with no `resp_valid`, and the next cycle shows the reset values.

## Timing

- **Reset values:**
  - `sram_ce` = 1, `sclk` = 0, `si` = 0
  - `req_ready` = 0, `resp_valid` = 0, `resp_rdata` = 0, `busy` = 0
  - FSM in IDLE; round-robin pointer = port 0.
- **Transaction timing** (grant in cycle T):
  - `sram_ce` falls at T+1.
  - The first bit is on `si` at T+1.
  - `resp_valid` is high at T+2N+2.
  - The earliest next grant is T+2N+4.
- **Latency from grant to `resp_valid`:**
  - byte: 82 cycles
  - half: 98 cycles
  - word: 130 cycles
- **Back-to-back requests:** a port's next request may be presented in the `resp_valid` cycle.

## Configuration

- Macro `SRAM_ARB_RR_EN`: selects the arbitration policy when both ports request in the same IDLE cycle.
- **Defined:** round-robin.
  - The port that did not win the last grant wins.
  - The pointer updates only on a grant.
- **Undefined:** fixed priority.
  - Port 0 (CPU) always wins over port 1.
  - The round-robin pointer logic is not built.

## Test plan

- **Reset:** hold `reset`=0 for 3 cycles with `req_valid`=2'b11 → every output at its reset value and no `req_ready`.
- **Port-0 word write then read:** write addr 0x000010, wdata 0xDEADBEEF, size 2; then read the same address →
  - SRAM model bytes 0x10..0x13 = EF BE AD DE;
  - `resp_rdata` = 0xDEADBEEF;
  - `resp_valid[0]` exactly 130 cycles after the grant;
  - bus sequence 0x02 / 0x000010 for the write and 0x03 / 0x000010 for the read.
- **Port-1 byte read at 0xFFFFFF (preload 0x5A), then half read at 0xFFFFFF (preload 0x000000 = 0xA5)** →
  - `resp_rdata` = 0x0000005A, with `resp_valid` at 82 cycles;
  - then `resp_rdata` = 0x0000A55A (wrap).
- **Contention:** both ports hold `req_valid` continuously for 4 transactions →
  - with `SRAM_ARB_RR_EN`: grants alternate 0, 1, 0, 1;
  - without it: port 0 gets all 4 grants, port 1 none.
- **Reset mid-SHIFT:** assert `reset`=0 40 cycles after the grant of a word read →
  - `sram_ce`=1 the next cycle;
  - no `resp_valid`;
  - a later request completes normally.
- **Withdrawn request:** drop `req_valid[1]` in the same cycle port 0 is granted → port 1 gets no grant and no SRAM traffic.
